// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: operand FIFO and issue FSM in front of the GCD controller/datapath.
// Optional job watchdog with machine abort reset: define GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         go,
    output logic [W-1:0] mach_a,
    output logic [W-1:0] mach_b,
    input  logic         done,
    input  logic         output_en,
    input  logic [W-1:0] gcd_result,
    output logic         mach_rst,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_err
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RESULT} state_t;
    state_t state;

    logic [W-1:0]  fifo_a [DEPTH];
    logic [W-1:0]  fifo_b [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [W-1:0]  head_a;
    logic [W-1:0]  head_b;

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0) && done && !out_valid;
    assign head_a   = fifo_a[rd_ptr];
    assign head_b   = fifo_b[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    logic          timed_out;
    assign timed_out = (timer == TW'(TIMEOUT - 1));
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign mach_rst       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            go        <= 1'b0;
            mach_a    <= '0;
            mach_b    <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
            timer     <= '0;
            mach_rst  <= 1'b0;
`endif
        end else begin
            go <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        mach_a <= head_a;
                        mach_b <= head_b;
                        // zero operands would never terminate in the machine: resolve here
                        if (head_a == '0 || head_b == '0) begin
                            out_valid <= 1'b1;
                            out_gcd   <= head_a | head_b;
                            out_err   <= (head_a == '0) && (head_b == '0);
                        end else begin
                            state <= ISSUE;
                            go    <= 1'b1;
                        end
                    end
                end
                ISSUE:     state <= WAIT_BUSY;
                WAIT_BUSY: if (!done) state <= WAIT_RESULT;
                WAIT_RESULT: begin
                    if (output_en) begin
                        out_valid <= 1'b1;
                        out_gcd   <= gcd_result;
                        out_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef GCD_SEQ_TIMEOUT_EN
            // watchdog overrides the case above; the abort cycle is followed by the error result
            if (state == IDLE && pop) timer <= '0;
            if (state == WAIT_BUSY || state == WAIT_RESULT) begin
                timer <= timer + TW'(1);
                if (mach_rst) begin
                    mach_rst  <= 1'b0;
                    out_valid <= 1'b1;
                    out_err   <= 1'b1;
                    out_gcd   <= '0;
                    state     <= IDLE;
                end else if (timed_out && !(state == WAIT_RESULT && output_en)) begin
                    mach_rst <= 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer with a behavioural GCD machine stub and result scoreboard.
module tb_gcd_job_sequencer;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         go;
    logic [W-1:0] mach_a;
    logic [W-1:0] mach_b;
    logic         done;
    logic         output_en;
    logic [W-1:0] gcd_result;
    logic         mach_rst;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;

    int total = 0;
    int bad   = 0;
    int go_total = 0;
    int nz_jobs  = 0;
    logic [W:0] exp_q [$];

    always #5 clk = ~clk;

    gcd_job_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .go(go), .mach_a(mach_a), .mach_b(mach_b),
        .done(done), .output_en(output_en), .gcd_result(gcd_result),
        .mach_rst(mach_rst), .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_err(out_err)
    );

    function automatic logic [W-1:0] gcd_euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // expected {err, gcd} for one operand pair
    function automatic logic [W:0] ref_job(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 0 || b == 0) return {(a == 0 && b == 0), a | b};
        return {1'b0, gcd_euclid(a, b)};
    endfunction

    function automatic int sub_steps(input int a, input int b);
        int n = 0;
        while (a != b) begin
            if (a > b) a -= b;
            else b -= a;
            n++;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 4) == 0) return '0;
        return W'($urandom_range(1, 30));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // machine stub: loads one cycle after go, output_en 3 cycles later plus 3 per subtraction
    logic         hang;
    logic         st_busy;
    int           st_cnt;
    logic [W-1:0] st_res;
    always @(posedge clk) begin
        if (rst || mach_rst) begin
            done <= 1'b1; output_en <= 1'b0; gcd_result <= '0; st_busy <= 1'b0; st_cnt <= 0;
        end else if (!st_busy) begin
            if (go) begin
                st_busy <= 1'b1;
                done    <= 1'b0;
                st_cnt  <= 2 + 3 * sub_steps(mach_a, mach_b);
                st_res  <= gcd_euclid(mach_a, mach_b);
            end
        end else if (output_en) begin
            output_en <= 1'b0; done <= 1'b1; st_busy <= 1'b0;
        end else if (st_cnt == 0) begin
            if (!hang) begin
                output_en  <= 1'b1;
                gcd_result <= st_res;
            end
        end else begin
            st_cnt <= st_cnt - 1;
        end
    end

    logic       prev_go, prev_ov, prev_rdy;
    logic [W:0] prev_out;
    always @(negedge clk) begin
        if (rst) begin
            prev_go = 1'b0; prev_ov = 1'b0; prev_rdy = 1'b0; prev_out = '0;
        end else begin
            if (go) begin
                check("go_single", prev_go, 0);
                go_total++;
            end
            if (prev_ov && !prev_rdy) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_err, out_gcd}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("result_extra", exp_q.size(), 1);
                else check("result", {out_err, out_gcd}, exp_q.pop_front());
            end
            prev_go = go; prev_ov = out_valid; prev_rdy = out_ready; prev_out = {out_err, out_gcd};
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && guard < 300) begin
            step();
            guard++;
        end
        if (!in_ready) check("push_timeout", in_ready, 1);
        else begin
            exp_q.push_back(ref_job(a, b));
            if (a != 0 && b != 0) nz_jobs++;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_ov,
                           input int exp_go, input logic [W-1:0] exp_gcd, input logic exp_err);
        int ngo = 0, fgo = -1, fov = -1, unstable = 0;
        logic [W-1:0] rg = '0;
        logic re = 1'b0;
        push(a, b);
        for (int k = 1; k <= exp_ov + 3; k++) begin
            if (go) begin
                ngo++;
                if (fgo < 0) fgo = k;
            end
            if (out_valid && fov < 0) begin
                fov = k; rg = out_gcd; re = out_err;
            end
            if (k >= 2 && (mach_a !== a || mach_b !== b)) unstable++;
            step();
        end
        check("go_count", ngo, exp_go);
        if (exp_go != 0) check("go_slot", fgo, 2);
        check("ov_slot", fov, exp_ov);
        check("gcd", rg, exp_gcd);
        check("err", re, exp_err);
        check("mach_hold", unstable, 0);
    endtask

    logic [W-1:0] jt_a   [5] = '{8'd7, 8'd12, 8'd0, 8'd5, 8'd0};
    logic [W-1:0] jt_b   [5] = '{8'd7, 8'd18, 8'd9, 8'd0, 8'd0};
    int           jt_ov  [5] = '{7, 13, 2, 2, 2};
    int           jt_go  [5] = '{1, 1, 0, 0, 0};
    logic [W-1:0] jt_gcd [5] = '{8'd7, 8'd6, 8'd9, 8'd5, 8'd0};
    logic         jt_err [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int acc, g0, guard, sent;
        logic was_acc;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; hang = 1'b0;
        step(3);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_go", go, 0);
        check("rst_mach", {mach_a, mach_b}, 0);
        check("rst_mach_rst", mach_rst, 0);
        check("rst_out", {out_valid, out_err, out_gcd}, 0);

        for (int j = 0; j < 5; j++) run_job(jt_a[j], jt_b[j], jt_ov[j], jt_go[j], jt_gcd[j], jt_err[j]);

        // back-pressure: FIFO plus the in-flight job fill, result holds
        out_ready = 1'b0; acc = 0; g0 = go_total;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom_range(1, 15));
            in_b = W'($urandom_range(1, 15));
            if (!in_ready) break;
            exp_q.push_back(ref_job(in_a, in_b));
            nz_jobs++; acc++;
            step();
        end
        check("accepted", acc, DEPTH + 1);
        check("in_ready_full", in_ready, 0);
        step(60);
        check("blocked_valid", out_valid, 1);
        check("blocked_result", {out_err, out_gcd}, exp_q[0]);
        check("blocked_go", go_total - g0, 1);
        check("in_ready_held", in_ready, 0);
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 300) begin
            step();
            guard++;
        end
        check("sixth_accept", in_ready, 1);
        exp_q.push_back(ref_job(in_a, in_b));
        nz_jobs++;
        step();
        in_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            step();
            guard++;
        end
        check("drain_bp", exp_q.size(), 0);

        // reset while the machine is stuck in WAIT_RESULT with another pair queued
        hang = 1'b1;
        push(8'd9, 8'd3);
        push(8'd5, 8'd5);
        step(8);
        rst = 1'b1;
        step();
        check("mr_in_ready", in_ready, 1);
        check("mr_go", go, 0);
        check("mr_mach", {mach_a, mach_b}, 0);
        check("mr_mach_rst", mach_rst, 0);
        check("mr_out", {out_valid, out_err, out_gcd}, 0);
        rst = 1'b0; hang = 1'b0;
        exp_q.delete();
        g0 = go_total;
        step(20);
        check("mr_fifo_empty_go", go_total - g0, 0);
        check("mr_fifo_empty_ov", out_valid, 0);
        go_total = 0; nz_jobs = 0;

`ifdef GCD_SEQ_TIMEOUT_EN
        begin
            int nr = 0, fr = -1, fov = -1;
            logic [W:0] r = '0;
            hang = 1'b1;
            push(8'd21, 8'd7);
            void'(exp_q.pop_back());
            exp_q.push_back({1'b1, 8'd0});
            for (int k = 1; k <= 30; k++) begin
                if (mach_rst) begin
                    nr++;
                    if (fr < 0) fr = k;
                end
                if (out_valid && fov < 0) begin
                    fov = k; r = {out_err, out_gcd};
                end
                step();
            end
            check("to_rst_count", nr, 1);
            check("to_rst_slot", fr, 23);
            check("to_ov_slot", fov, 24);
            check("to_result", r, {1'b1, 8'd0});
            hang = 1'b0;
        end
`endif

        // randomized traffic with random back-pressure
        sent = 0; guard = 0;
        while (sent < 30 && guard < 5000) begin
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            was_acc = in_valid && in_ready;
            if (was_acc) begin
                exp_q.push_back(ref_job(in_a, in_b));
                if (in_a != 0 && in_b != 0) nz_jobs++;
                sent++;
            end
            step();
            if (was_acc) in_valid = 1'b0;
            guard++;
        end
        check("rand_sent", sent, 30);
        out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 5000) begin
            step();
            guard++;
        end
        check("drain_rand", exp_q.size(), 0);
        check("go_per_job", go_total, nz_jobs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
